// File: rtl/vpu_exec_sequencer_if.sv
// rtl/vpu_exec_sequencer_if.sv - instruction, source-port, VLANE and write-back handshakes of the exec sequencer
interface vpu_exec_sequencer_if #(
    parameter int R_PORT_CNT = 3
);
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [R_PORT_CNT-1:0] instr_rvalid_i;
    logic                  src_start_o;
    logic                  src_done_i;
    logic                  dst_ready_i;
    logic [R_PORT_CNT-1:0] operand_fifo_rden_o;
    logic                  vlane_valid_o;
    logic [3:0]            beat_idx_o;
    logic                  exec_done_o;
    logic                  busy_o;

    modport master (
        output instr_valid_i, instr_rvalid_i, src_done_i, dst_ready_i,
        input  instr_ready_o, src_start_o, operand_fifo_rden_o, vlane_valid_o,
               beat_idx_o, exec_done_o, busy_o
    );

    modport slave (
        input  instr_valid_i, instr_rvalid_i, src_done_i, dst_ready_i,
        output instr_ready_o, src_start_o, operand_fifo_rden_o, vlane_valid_o,
               beat_idx_o, exec_done_o, busy_o
    );
endinterface

// File: rtl/vpu_exec_sequencer.sv
// rtl/vpu_exec_sequencer.sv - sequences operand fetch, beat issue and VLANE drain for one vector instruction
// Optional performance counters are enabled by defining VPU_EXEC_SEQ_PERF_EN.
module vpu_exec_sequencer #(
    parameter int R_PORT_CNT = 3,
    parameter int EXEC_CNT   = 2,
    parameter int EXEC_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    vpu_exec_sequencer_if.slave   seq
`ifdef VPU_EXEC_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_instr_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_DRAIN
    } state_t;

    localparam logic [3:0] LAST_BEAT  = 4'(EXEC_CNT - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(EXEC_LAT - 1);

    state_t                state_q, state_d;
    logic [R_PORT_CNT-1:0] rvalid_q, rvalid_d;
    logic [3:0]            beat_q, beat_d;
    logic [2:0]            drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rvalid_q <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        rvalid_d                = rvalid_q;
        beat_d                  = beat_q;
        drain_d                 = drain_q;
        seq.instr_ready_o       = 1'b0;
        seq.src_start_o         = 1'b0;
        seq.operand_fifo_rden_o = '0;
        seq.vlane_valid_o       = 1'b0;
        seq.beat_idx_o          = '0;
        seq.exec_done_o         = 1'b0;
        seq.busy_o              = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                seq.instr_ready_o = 1'b1;
                if (seq.instr_valid_i) begin
                    rvalid_d = seq.instr_rvalid_i;
                    beat_d   = '0;
                    state_d  = (|seq.instr_rvalid_i) ? S_FETCH : S_EXEC;
                end
            end
            S_FETCH: begin
                seq.src_start_o = 1'b1;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                if (seq.src_done_i) begin
                    beat_d  = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A beat issues only when write-back can accept it; otherwise stall in place.
                if (seq.dst_ready_i) begin
                    seq.vlane_valid_o       = 1'b1;
                    seq.operand_fifo_rden_o = rvalid_q;
                    seq.beat_idx_o          = beat_q;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        drain_d = DRAIN_INIT;
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    seq.exec_done_o = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs show the reset state already in the reset cycle, cancelling any pending start pulse.
        if (rst) begin
            seq.instr_ready_o       = 1'b1;
            seq.src_start_o         = 1'b0;
            seq.operand_fifo_rden_o = '0;
            seq.vlane_valid_o       = 1'b0;
            seq.beat_idx_o          = '0;
            seq.exec_done_o         = 1'b0;
            seq.busy_o              = 1'b0;
        end
    end

`ifdef VPU_EXEC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (seq.exec_done_o && (perf_instr_cnt_o != 32'hFFFF_FFFF))
                perf_instr_cnt_o <= perf_instr_cnt_o + 32'd1;
            if ((state_q == S_EXEC) && !seq.dst_ready_i && (perf_stall_cnt_o != 32'hFFFF_FFFF))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vpu_exec_sequencer.sv
// tb/tb_vpu_exec_sequencer.sv - randomized self-checking bench for vpu_exec_sequencer against a timeline model
module tb_vpu_exec_sequencer;
    localparam int RP    = 3;
    localparam int A_CNT = 2;
    localparam int A_LAT = 1;
    localparam int B_CNT = 4;
    localparam int B_LAT = 3;
    localparam int MAXC  = 64;
    localparam logic [11:0] IDLE_V = 12'h800;
    localparam logic [11:0] BUSY_V = 12'h001;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic [RP-1:0] instr_rvalid;
    logic          src_done;
    logic          dst_ready;
    int            checks = 0;
    int            errors = 0;
    int            exp_pi[2];
    int            exp_ps[2];

    vpu_exec_sequencer_if #(.R_PORT_CNT(RP)) ifa ();
    vpu_exec_sequencer_if #(.R_PORT_CNT(RP)) ifb ();

    assign ifa.instr_valid_i  = instr_valid;
    assign ifa.instr_rvalid_i = instr_rvalid;
    assign ifa.src_done_i     = src_done;
    assign ifa.dst_ready_i    = dst_ready;
    assign ifb.instr_valid_i  = instr_valid;
    assign ifb.instr_rvalid_i = instr_rvalid;
    assign ifb.src_done_i     = src_done;
    assign ifb.dst_ready_i    = dst_ready;

`ifdef VPU_EXEC_SEQ_PERF_EN
    logic [31:0] pa_instr, pa_stall, pb_instr, pb_stall;
`endif

    vpu_exec_sequencer #(.R_PORT_CNT(RP), .EXEC_CNT(A_CNT), .EXEC_LAT(A_LAT)) dut_a (
        .clk(clk), .rst(rst), .seq(ifa)
`ifdef VPU_EXEC_SEQ_PERF_EN
        , .perf_instr_cnt_o(pa_instr), .perf_stall_cnt_o(pa_stall)
`endif
    );

    vpu_exec_sequencer #(.R_PORT_CNT(RP), .EXEC_CNT(B_CNT), .EXEC_LAT(B_LAT)) dut_b (
        .clk(clk), .rst(rst), .seq(ifb)
`ifdef VPU_EXEC_SEQ_PERF_EN
        , .perf_instr_cnt_o(pb_instr), .perf_stall_cnt_o(pb_stall)
`endif
    );

    always #5 clk = ~clk;

    // {ready, start, vlane_valid, beat_idx[3:0], rden[2:0], done, busy}
    function automatic logic [11:0] obs(input int sel);
        if (sel == 0)
            return {ifa.instr_ready_o, ifa.src_start_o, ifa.vlane_valid_o, ifa.beat_idx_o,
                    ifa.operand_fifo_rden_o, ifa.exec_done_o, ifa.busy_o};
        return {ifb.instr_ready_o, ifb.src_start_o, ifb.vlane_valid_o, ifb.beat_idx_o,
                ifb.operand_fifo_rden_o, ifb.exec_done_o, ifb.busy_o};
    endfunction

    task automatic do_reset(input string name);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst          = (c < 2);
            instr_valid  = 1'($urandom);
            instr_rvalid = 3'($urandom);
            src_done     = 1'($urandom);
            dst_ready    = 1'($urandom);
            if (c == 2) instr_valid = 1'b0;
            #1;
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== IDLE_V) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc %0d: got %b expected %b", name, s, c, obs(s), IDLE_V);
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            exp_pi[s] = 0;
            exp_ps[s] = 0;
        end
    endtask

`ifdef VPU_EXEC_SEQ_PERF_EN
    task automatic check_perf(input int sel, input string name);
        logic [31:0] gi, gs;
        @(negedge clk);
        instr_valid = 1'b0;
        src_done    = 1'b0;
        #1;
        gi = (sel == 0) ? pa_instr : pb_instr;
        gs = (sel == 0) ? pa_stall : pb_stall;
        checks++;
        if (gi !== 32'(exp_pi[sel])) begin
            errors++;
            $display("FAIL %s perf_instr: got %0d expected %0d", name, gi, exp_pi[sel]);
        end
        checks++;
        if (gs !== 32'(exp_ps[sel])) begin
            errors++;
            $display("FAIL %s perf_stall: got %0d expected %0d", name, gs, exp_ps[sel]);
        end
    endtask
`endif

    // Builds the expected cycle-by-cycle timeline of one instruction from its rules, then drives and compares.
    task automatic run_instr(input int sel, input logic [RP-1:0] rv, input int dd, input int rmode,
                             input int abort_at, input bit noise, input string name);
        int cnt, lat, ex_start, last, done_c, k, stalls, ncyc, c;
        bit rdy[MAXC];
        bit sd[MAXC];
        bit ivn[MAXC];
        logic [RP-1:0] rvn[MAXC];
        logic [11:0] exp[MAXC];
        cnt      = (sel == 0) ? A_CNT : B_CNT;
        lat      = (sel == 0) ? A_LAT : B_LAT;
        ex_start = (rv != 0) ? 2 + dd : 1;
        last     = 0;
        for (int i = 0; i < MAXC; i++) begin
            sd[i]  = noise ? 1'($urandom) : 1'b0;
            ivn[i] = noise ? 1'($urandom) : 1'b0;
            rvn[i] = RP'($urandom);
            exp[i] = BUSY_V;
            if (i < ex_start) rdy[i] = 1'($urandom);
            else if (rmode == 0) rdy[i] = 1'b1;
            else if (rmode == 1) rdy[i] = ((i - ex_start) % 2 == 0);
            else rdy[i] = (i - ex_start > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        if (rv != 0) begin
            for (int i = 2; i <= 1 + dd; i++) sd[i] = 1'b0;
            sd[1 + dd] = 1'b1;
            exp[1] = {1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1};
        end
        exp[0] = IDLE_V;
        k      = 0;
        stalls = 0;
        c      = ex_start;
        while (k < cnt) begin
            if (rdy[c]) begin
                exp[c] = {1'b0, 1'b0, 1'b1, 4'(k), rv, 1'b0, 1'b1};
                k++;
                if (k == cnt) last = c;
            end else begin
                stalls++;
            end
            c++;
        end
        done_c      = last + lat;
        exp[done_c] = {1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1};
        ncyc        = done_c + 1;
        if (abort_at >= 0) begin
            for (int i = abort_at; i < MAXC; i++) begin
                exp[i] = IDLE_V;
                ivn[i] = 1'b0;
            end
            ncyc = abort_at + 2;
        end

        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst          = (i == abort_at);
            instr_valid  = (i == 0) ? 1'b1 : ivn[i];
            instr_rvalid = (i == 0) ? rv : rvn[i];
            src_done     = sd[i];
            dst_ready    = rdy[i];
            #1;
            checks++;
            if (obs(sel) !== exp[i]) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b expected %b", name, i, obs(sel), exp[i]);
            end
        end
        rst = 1'b0;
        if (abort_at >= 0) begin
            for (int s = 0; s < 2; s++) begin
                exp_pi[s] = 0;
                exp_ps[s] = 0;
            end
        end else begin
            exp_pi[sel] = exp_pi[sel] + 1;
            exp_ps[sel] = exp_ps[sel] + stalls;
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_fetch_path();
        do_reset("fetch_rst");
        run_instr(0, 3'b011, 2, 0, -1, 1'b0, "fetch_011");
        run_instr(0, 3'b100, 1, 0, -1, 1'b0, "fetch_100");
    endtask

    task automatic test_no_fetch();
        do_reset("nofetch_rst");
        run_instr(0, 3'b000, 1, 0, -1, 1'b0, "nofetch");
    endtask

    task automatic test_stall();
        do_reset("stall_rst");
        run_instr(1, 3'b000, 1, 1, -1, 1'b0, "stall_rv0");
`ifdef VPU_EXEC_SEQ_PERF_EN
        check_perf(1, "stall_perf");
`endif
        run_instr(1, 3'b101, 3, 1, -1, 1'b0, "stall_rv5");
    endtask

    task automatic test_reset_mid();
        do_reset("mid_rst");
        run_instr(0, 3'b011, 1, 0, 4, 1'b0, "abort_beat1");
        run_instr(0, 3'b011, 1, 0, -1, 1'b0, "after_abort");
    endtask

    task automatic test_idle_src_done();
        do_reset("idle_sd_rst");
        @(negedge clk);
        instr_valid = 1'b0;
        src_done    = 1'b1;
        dst_ready   = 1'b1;
        #1;
        checks++;
        if (obs(1) !== IDLE_V) begin
            errors++;
            $display("FAIL idle_src_done: got %b expected %b", obs(1), IDLE_V);
        end
        src_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_instr(1, 3'b110, 1, 0, -1, 1'b1, "b2b_first");
        run_instr(1, 3'b001, 2, 0, -1, 1'b1, "b2b_second");
`ifdef VPU_EXEC_SEQ_PERF_EN
        check_perf(1, "b2b_perf");
`endif
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            do_reset("rand_rst");
            for (int n = 0; n < 15; n++)
                run_instr(s, RP'($urandom), $urandom_range(1, 4), $urandom_range(0, 2), -1, 1'b1, "random");
`ifdef VPU_EXEC_SEQ_PERF_EN
            check_perf(s, "rand_perf");
`endif
        end
    endtask

    initial begin
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr_rvalid = '0;
        src_done     = 1'b0;
        dst_ready    = 1'b0;
        test_reset();
        test_fetch_path();
        test_no_fetch();
        test_stall();
        test_reset_mid();
        test_idle_src_done();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vpu_exec_sequencer.md
VPU_EXEC_SEQUENCER -- requirements
Module: vpu_exec_sequencer

Interface
REQ-001 SHALL have parameter R_PORT_CNT, default 3: number of source (SRAM read) ports.
REQ-002 SHALL have parameter EXEC_CNT, default 2: execution beats per instruction (valid range 1..16).
REQ-003 SHALL have parameter EXEC_LAT, default 1: VLANE result latency in cycles (valid range 1..8).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 instr_valid_i  in  1  decoded instruction available.
REQ-008 instr_ready_o  out  1  sequencer accepts instruction (IDLE only).
REQ-009 instr_rvalid_i  in  R_PORT_CNT  per-port operand-read enable of the offered instruction.
REQ-010 src_start_o  out  1  one-cycle start pulse to the source-port block.
REQ-011 src_done_i  in  1  all enabled source ports have their operands buffered.
REQ-012 dst_ready_i  in  1  destination/write-back path can take a beat.
REQ-013 operand_fifo_rden_o  out  R_PORT_CNT  per-port operand read strobe for the current beat.
REQ-014 vlane_valid_o  out  1  beat issued to the VLANE this cycle.
REQ-015 beat_idx_o  out  4  index of the issued beat (0..EXEC_CNT-1).
REQ-016 exec_done_o  out  1  one-cycle pulse: last result is out of the VLANE.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT, EXEC, DRAIN.
REQ-019 IDLE: instr_ready_o=1; on instr_valid_i=1 SHALL latch instr_rvalid_i into rvalid_q and go to FETCH if rvalid_q!=0, else EXEC.
REQ-020 FETCH: src_start_o=1 for exactly this one cycle; next state WAIT unconditionally.
REQ-021 WAIT: SHALL ignore src_done_i in the FETCH cycle; on src_done_i=1 go to EXEC next cycle with beat counter=0.
REQ-022 EXEC: a beat issues only in a cycle with dst_ready_i=1; then vlane_valid_o=1, operand_fifo_rden_o=rvalid_q, beat_idx_o=counter, and the counter increments.
REQ-023 EXEC with dst_ready_i=0: vlane_valid_o=0, operand_fifo_rden_o=0, counter held (stall).
REQ-024 The issue of beat EXEC_CNT-1 SHALL move the FSM to DRAIN with drain counter=EXEC_LAT-1.
REQ-025 DRAIN: decrement each cycle; in the cycle the counter is 0, exec_done_o=1 and next state is IDLE.
REQ-026 Minimum latency from instruction accept to exec_done_o: FETCH(1)+WAIT(>=1)+EXEC_CNT+EXEC_LAT cycles; with rvalid=0, EXEC_CNT+EXEC_LAT.
REQ-027 src_done_i outside WAIT and instr_valid_i outside IDLE SHALL be ignored.
REQ-028 beat_idx_o SHALL be 0 when vlane_valid_o=0.
REQ-029 The beat counter SHALL never exceed EXEC_CNT-1; there is no wrap within an instruction.
REQ-030 Back-to-back: exec_done_o cycle is followed by IDLE, so the next accept occurs no earlier than 1 cycle after exec_done_o.

Reset
REQ-031 rst=1 SHALL force IDLE, clear rvalid_q and all counters, in any state including mid-EXEC/DRAIN.
REQ-032 Outputs during and after reset: instr_ready_o=1, all other outputs 0; a pending src_start_o SHALL be cancelled.

Configuration
REQ-033 Macro VPU_EXEC_SEQ_PERF_EN defined: SHALL add outputs perf_instr_cnt_o (32, +1 per exec_done_o) and perf_stall_cnt_o (32, +1 per EXEC cycle with dst_ready_i=0), both saturating, cleared by rst.
REQ-034 Macro not defined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-035 Defaults, rvalid=3'b011, src_done_i 2 cycles after FETCH, dst_ready_i=1 -> src_start_o one pulse; rden=011 on beats 0,1 in consecutive cycles; exec_done_o 1 cycle after beat 1.
REQ-036 rvalid=3'b000 -> no src_start_o; 2 beats start the cycle after accept, rden=000, vlane_valid_o=1.
REQ-037 EXEC_CNT=4, dst_ready_i low every other cycle -> beat_idx_o 0,1,2,3 only on ready cycles, no duplicates; perf_stall_cnt_o=3 (PERF_EN).
REQ-038 rst pulsed during beat 1 -> next cycle IDLE, all outputs 0 except instr_ready_o=1; a new instruction then runs normally.
REQ-039 EXEC_LAT=3, two back-to-back instructions -> exec_done_o 3 cycles after each last beat; perf_instr_cnt_o=2; src_done_i pulsed in IDLE has no effect.
